// File: rtl/udp_cmd_pkg.sv
// -----------------------------------------------------------------------------
// udp_cmd_pkg
//   Shared constants for the UDP command decoder: frame sync byte, opcode
//   values, the payload length each opcode requires, the parser state
//   encoding and a saturating counter helper.
// -----------------------------------------------------------------------------
package udp_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] OPC_SET_ADDR   = 8'h01;
  localparam logic [7:0] OPC_SELF_CHECK = 8'h02;
  localparam logic [7:0] OPC_NWR_EN     = 8'h03;
  localparam logic [7:0] OPC_CLR_STATS  = 8'h04;

  localparam logic [7:0] LEN_SET_ADDR   = 8'd5;
  localparam logic [7:0] LEN_SELF_CHECK = 8'd0;
  localparam logic [7:0] LEN_NWR_EN     = 8'd1;
  localparam logic [7:0] LEN_CLR_STATS  = 8'd0;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Each state names the byte the parser is waiting for next
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_LEN,
    ST_PAY,
    ST_CSUM
  } state_t;

  // Frame statistics stick at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/udp_cmd_timeout.sv
// -----------------------------------------------------------------------------
// udp_cmd_timeout
//   Idle watchdog for a frame in progress. Counts cycles in which the parser
//   is busy but no byte arrives; any valid byte, or the parser going idle,
//   clears the count. expire is a combinational one-cycle strobe on the
//   TIMEOUT_CYC-th consecutive idle cycle, so the parser can abort on the
//   same clock edge.
//   Only instantiated when UDP_CMD_TIMEOUT_EN is defined.
// Ports
//   clk     in  clock
//   reset   in  synchronous active-high reset
//   busy    in  parser is inside a frame
//   valid   in  a command byte is present this cycle
//   expire  out idle limit reached this cycle
// -----------------------------------------------------------------------------
module udp_cmd_timeout
  import udp_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic valid,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             counting;

  assign counting = busy && !valid;
  assign expire   = counting && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // The count restarts after expiry so a stale value never leaks into the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!counting || expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/udp_cmd_decoder.sv
// -----------------------------------------------------------------------------
// udp_cmd_decoder
//   Parses the byte stream from the Ethernet/UDP stage into SRIO control.
//   Frame: A5 | OPCODE | LEN | PAYLOAD[LEN] | CSUM, CSUM = XOR(OPCODE, LEN,
//   payload). Accepted commands update the target address, pulse the
//   self-check trigger, set the NWRITE enable or clear the statistics.
//   All effects are registered on the edge that consumes the CSUM byte.
// Configuration
//   UDP_CMD_TIMEOUT_EN  when defined, a frame idle for TIMEOUT_CYC cycles is
//                       aborted as a rejected frame; otherwise a partial frame
//                       waits indefinitely.
// Ports
//   clk_udp            in   clock
//   reset_udp          in   synchronous active-high reset
//   cmd_data_in        in   command byte
//   cmd_valid_in       in   byte qualifier, every valid byte is consumed
//   taddr_out          out  SRIO target address (held)
//   taddr_update_out   out  pulse on accepted SET_ADDR
//   self_check_out     out  pulse on accepted SELF_CHECK
//   nwr_enable_out     out  NWRITE enable level
//   busy_out           out  frame in progress
//   err_out            out  pulse on any rejected frame
//   frame_ok_cnt_out   out  accepted-frame count, saturating
//   frame_err_cnt_out  out  rejected-frame count, saturating
// -----------------------------------------------------------------------------
module udp_cmd_decoder
  import udp_cmd_pkg::*;
#(
  parameter int ADDR_W      = 34,
  parameter int MAX_PAYLOAD = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_udp,
  input  logic              reset_udp,
  input  logic [7:0]        cmd_data_in,
  input  logic              cmd_valid_in,
  output logic [ADDR_W-1:0] taddr_out,
  output logic              taddr_update_out,
  output logic              self_check_out,
  output logic              nwr_enable_out,
  output logic              busy_out,
  output logic              err_out,
  output logic [15:0]       frame_ok_cnt_out,
  output logic [15:0]       frame_err_cnt_out
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_t      state_q, state_d;
  logic [7:0]  opcode_q;
  logic [7:0]  len_q;
  logic [7:0]  csum_q;
  logic [7:0]  idx_q;
  logic [7:0]  pay_q [MAX_PAYLOAD];

  logic        timeout_expire;
  logic        len_reject;
  logic        frame_end;
  logic        csum_good;
  logic        do_set_addr;
  logic        do_self_check;
  logic        do_nwr_en;
  logic        do_clr_stats;
  logic        cmd_accept;
  logic        cmd_reject;
  logic [ADDR_W-1:0] addr_next;

  assign busy_out = (state_q != ST_IDLE);

`ifdef UDP_CMD_TIMEOUT_EN
  udp_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk_udp),
    .reset (reset_udp),
    .busy  (busy_out),
    .valid (cmd_valid_in),
    .expire(timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  always_ff @(posedge clk_udp) begin
    if (reset_udp) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each transition consumes exactly one valid byte; a timeout only fires on
  // idle cycles so it never competes with a byte
  always_comb begin
    state_d    = state_q;
    len_reject = 1'b0;
    frame_end  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_in && (cmd_data_in == SYNC_BYTE)) begin
          state_d = ST_OPC;
        end
      end
      ST_OPC: begin
        if (cmd_valid_in) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (cmd_valid_in) begin
          if (cmd_data_in > MAX_LEN) begin
            state_d    = ST_IDLE;
            len_reject = 1'b1;
          end else if (cmd_data_in == 8'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (cmd_valid_in && (idx_q == len_q - 8'd1)) begin
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (cmd_valid_in) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout_expire) begin
      state_d = ST_IDLE;
    end
  end

  // Command decode on the CSUM byte; the address is the first five payload
  // bytes shifted in MSB first, keeping only the low ADDR_W bits
  always_comb begin
    csum_good     = (cmd_data_in == csum_q);
    do_set_addr   = 1'b0;
    do_self_check = 1'b0;
    do_nwr_en     = 1'b0;
    do_clr_stats  = 1'b0;
    addr_next     = '0;
    for (int i = 0; i < 5; i++) begin
      addr_next = {addr_next[ADDR_W-9:0], pay_q[i]};
    end
    if (frame_end && csum_good) begin
      case (opcode_q)
        OPC_SET_ADDR:   do_set_addr   = (len_q == LEN_SET_ADDR);
        OPC_SELF_CHECK: do_self_check = (len_q == LEN_SELF_CHECK);
        OPC_NWR_EN:     do_nwr_en     = (len_q == LEN_NWR_EN);
        OPC_CLR_STATS:  do_clr_stats  = (len_q == LEN_CLR_STATS);
        default:        ;
      endcase
    end
    cmd_accept = do_set_addr || do_self_check || do_nwr_en || do_clr_stats;
    cmd_reject = len_reject || timeout_expire || (frame_end && !cmd_accept);
  end

  // Frame capture: opcode, length, running checksum and payload bytes
  always_ff @(posedge clk_udp) begin
    if (reset_udp) begin
      opcode_q <= '0;
      len_q    <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
        pay_q[i] <= '0;
      end
    end else if (cmd_valid_in) begin
      case (state_q)
        ST_OPC: begin
          opcode_q <= cmd_data_in;
          csum_q   <= cmd_data_in;
        end
        ST_LEN: begin
          len_q  <= cmd_data_in;
          csum_q <= csum_q ^ cmd_data_in;
          idx_q  <= '0;
        end
        ST_PAY: begin
          for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx_q == 8'(i)) begin
              pay_q[i] <= cmd_data_in;
            end
          end
          csum_q <= csum_q ^ cmd_data_in;
          idx_q  <= idx_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered command effects, pulses and statistics; CLR_STATS is not itself counted
  always_ff @(posedge clk_udp) begin
    if (reset_udp) begin
      taddr_out         <= '0;
      taddr_update_out  <= 1'b0;
      self_check_out    <= 1'b0;
      nwr_enable_out    <= 1'b1;
      err_out           <= 1'b0;
      frame_ok_cnt_out  <= '0;
      frame_err_cnt_out <= '0;
    end else begin
      taddr_update_out <= do_set_addr;
      self_check_out   <= do_self_check;
      err_out          <= cmd_reject;
      if (do_set_addr) begin
        taddr_out <= addr_next;
      end
      if (do_nwr_en) begin
        nwr_enable_out <= pay_q[0][0];
      end
      if (do_clr_stats) begin
        frame_ok_cnt_out  <= '0;
        frame_err_cnt_out <= '0;
      end else begin
        if (cmd_accept) begin
          frame_ok_cnt_out <= sat_inc(frame_ok_cnt_out);
        end
        if (cmd_reject) begin
          frame_err_cnt_out <= sat_inc(frame_err_cnt_out);
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_udp_cmd_decoder
//   Drives udp_cmd_decoder with directed and randomized command frames and
//   compares every output, every cycle, against a frame-level model that
//   collects each frame's bytes and judges the whole frame once complete.
//   With UDP_CMD_TIMEOUT_EN defined the model also applies the idle abort.
// -----------------------------------------------------------------------------
module tb_udp_cmd_decoder;

  localparam int ADDR_W      = 34;
  localparam int MAX_PAYLOAD = 8;
  localparam int TIMEOUT_CYC = 1024;

  typedef logic [7:0] bytes_t[$];

  logic              clk_udp = 1'b0;
  logic              reset_udp = 1'b1;
  logic [7:0]        cmd_data_in = 8'h00;
  logic              cmd_valid_in = 1'b0;
  logic [ADDR_W-1:0] taddr_out;
  logic              taddr_update_out;
  logic              self_check_out;
  logic              nwr_enable_out;
  logic              busy_out;
  logic              err_out;
  logic [15:0]       frame_ok_cnt_out;
  logic [15:0]       frame_err_cnt_out;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model state: expected outputs plus the bytes of the frame being collected
  logic [ADDR_W-1:0] m_taddr;
  logic              m_upd, m_sc, m_nwr, m_busy, m_err;
  logic [15:0]       m_ok, m_errc;
  logic [7:0]        frame_q[$];
  bit                in_frame;
  int                idle_cnt;

  always #5 clk_udp = ~clk_udp;

  udp_cmd_decoder #(
    .ADDR_W     (ADDR_W),
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_udp          (clk_udp),
    .reset_udp        (reset_udp),
    .cmd_data_in      (cmd_data_in),
    .cmd_valid_in     (cmd_valid_in),
    .taddr_out        (taddr_out),
    .taddr_update_out (taddr_update_out),
    .self_check_out   (self_check_out),
    .nwr_enable_out   (nwr_enable_out),
    .busy_out         (busy_out),
    .err_out          (err_out),
    .frame_ok_cnt_out (frame_ok_cnt_out),
    .frame_err_cnt_out(frame_err_cnt_out)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic modelReject();
    m_err    = 1'b1;
    m_errc   = sat(m_errc);
    in_frame = 1'b0;
    frame_q.delete();
  endtask

  // Whole-frame judgement: frame_q holds OPCODE, LEN, payload and CSUM
  task automatic modelEval();
    int         n;
    logic [7:0] x;
    logic [7:0] opc, len, p0;
    logic [39:0] addr40;
    n = frame_q.size();
    x = 8'h00;
    for (int i = 0; i < n - 1; i++) x ^= frame_q[i];
    opc = frame_q[0];
    len = frame_q[1];
    if (x != frame_q[n-1]) begin
      modelReject();
      return;
    end
    in_frame = 1'b0;
    if (opc == 8'h01 && len == 8'd5) begin
      addr40  = {frame_q[2], frame_q[3], frame_q[4], frame_q[5], frame_q[6]};
      m_taddr = addr40[ADDR_W-1:0];
      m_upd   = 1'b1;
      m_ok    = sat(m_ok);
    end else if (opc == 8'h02 && len == 8'd0) begin
      m_sc = 1'b1;
      m_ok = sat(m_ok);
    end else if (opc == 8'h03 && len == 8'd1) begin
      p0    = frame_q[2];
      m_nwr = p0[0];
      m_ok  = sat(m_ok);
    end else if (opc == 8'h04 && len == 8'd0) begin
      m_ok   = 16'd0;
      m_errc = 16'd0;
    end else begin
      modelReject();
    end
    frame_q.delete();
  endtask

  // One clock edge of the model, given what the DUT sampled on that edge
  task automatic modelStep(input logic rst, input logic v, input logic [7:0] d);
    m_upd = 1'b0;
    m_sc  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_taddr  = '0;
      m_nwr    = 1'b1;
      m_ok     = 16'd0;
      m_errc   = 16'd0;
      in_frame = 1'b0;
      idle_cnt = 0;
      frame_q.delete();
    end else if (v) begin
      idle_cnt = 0;
      if (!in_frame) begin
        if (d == 8'hA5) begin
          in_frame = 1'b1;
          frame_q.delete();
        end
      end else begin
        frame_q.push_back(d);
        if (frame_q.size() == 2 && frame_q[1] > MAX_PAYLOAD) begin
          modelReject();
        end else if (frame_q.size() >= 2 && frame_q.size() == int'(frame_q[1]) + 3) begin
          modelEval();
        end
      end
    end
`ifdef UDP_CMD_TIMEOUT_EN
    else if (in_frame) begin
      idle_cnt++;
      if (idle_cnt == TIMEOUT_CYC) begin
        modelReject();
        idle_cnt = 0;
      end
    end
`endif
    m_busy = in_frame;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    cmd_valid_in = v;
    cmd_data_in  = d;
    @(posedge clk_udp);
    modelStep(reset_udp, v, d);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'($urandom));
    applyStimulus(1'b1, b);
  endtask

  // Sends A5, opcode, len, payload bytes, checksum (optionally corrupted)
  task automatic sendCmd(input logic [7:0] opc, input logic [7:0] len, input bytes_t pay,
                         input logic [7:0] csum_flip, input int max_gap);
    logic [7:0] x;
    x = opc ^ len;
    foreach (pay[i]) x ^= pay[i];
    sendByte(8'hA5, max_gap);
    sendByte(opc, max_gap);
    sendByte(len, max_gap);
    foreach (pay[i]) sendByte(pay[i], max_gap);
    sendByte(x ^ csum_flip, max_gap);
  endtask

  always @(negedge clk_udp) begin
    if (check_en) begin
      checkOutput("taddr_out", 64'(taddr_out), 64'(m_taddr));
      checkOutput("taddr_update_out", 64'(taddr_update_out), 64'(m_upd));
      checkOutput("self_check_out", 64'(self_check_out), 64'(m_sc));
      checkOutput("nwr_enable_out", 64'(nwr_enable_out), 64'(m_nwr));
      checkOutput("busy_out", 64'(busy_out), 64'(m_busy));
      checkOutput("err_out", 64'(err_out), 64'(m_err));
      checkOutput("frame_ok_cnt_out", 64'(frame_ok_cnt_out), 64'(m_ok));
      checkOutput("frame_err_cnt_out", 64'(frame_err_cnt_out), 64'(m_errc));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bytes_t pay;
    int     kind;
    logic [7:0] opc, len;

    // Reset
    reset_udp = 1'b1;
    applyStimulus(1'b0, 8'h00);
    check_en = 1'b1;
    applyStimulus(1'b0, 8'h00);
    reset_udp = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_reset_taddr", 64'(taddr_out), 64'h0);
    checkOutput("lit_reset_nwr", 64'(nwr_enable_out), 64'h1);
    checkOutput("lit_reset_busy", 64'(busy_out), 64'h0);
    checkOutput("lit_reset_ok", 64'(frame_ok_cnt_out), 64'h0);

    // SET_ADDR 00 00 00 12 34: checksum 01^05^12^34 = 22
    sendCmd(8'h01, 8'h05, '{8'h00, 8'h00, 8'h00, 8'h12, 8'h34}, 8'h00, 0);
    checkOutput("lit_set_addr_taddr", 64'(taddr_out), 64'h1234);
    checkOutput("lit_set_addr_pulse", 64'(taddr_update_out), 64'h1);
    checkOutput("lit_set_addr_ok", 64'(frame_ok_cnt_out), 64'h1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_set_addr_pulse_end", 64'(taddr_update_out), 64'h0);

    // SELF_CHECK then NWR_EN=0
    sendCmd(8'h02, 8'h00, '{}, 8'h00, 0);
    checkOutput("lit_self_check", 64'(self_check_out), 64'h1);
    sendCmd(8'h03, 8'h01, '{8'h00}, 8'h00, 0);
    checkOutput("lit_nwr_off", 64'(nwr_enable_out), 64'h0);
    checkOutput("lit_ok_three", 64'(frame_ok_cnt_out), 64'h3);

    // Bad checksum, then bad opcode with a correct checksum
    sendCmd(8'h02, 8'h00, '{}, 8'hFD, 0);
    checkOutput("lit_bad_csum_err", 64'(err_out), 64'h1);
    sendCmd(8'h07, 8'h00, '{}, 8'h00, 0);
    checkOutput("lit_bad_opc_err", 64'(err_out), 64'h1);
    checkOutput("lit_err_two", 64'(frame_err_cnt_out), 64'h2);
    checkOutput("lit_taddr_kept", 64'(taddr_out), 64'h1234);

    // Oversized LEN is rejected on the LEN byte itself
    sendByte(8'hA5, 0);
    checkOutput("lit_busy_in_frame", 64'(busy_out), 64'h1);
    sendByte(8'h01, 0);
    sendByte(8'h09, 0);
    checkOutput("lit_len_err", 64'(err_out), 64'h1);
    checkOutput("lit_len_idle", 64'(busy_out), 64'h0);
    sendCmd(8'h02, 8'h00, '{}, 8'h00, 0);
    checkOutput("lit_after_len_sc", 64'(self_check_out), 64'h1);
    checkOutput("lit_after_len_ok", 64'(frame_ok_cnt_out), 64'h4);

    // Reset in the middle of a gappy SET_ADDR frame
    sendByte(8'hA5, 3);
    sendByte(8'h01, 3);
    sendByte(8'h05, 3);
    sendByte(8'hAB, 3);
    sendByte(8'hCD, 3);
    reset_udp = 1'b1;
    applyStimulus(1'b0, 8'h00);
    reset_udp = 1'b0;
    checkOutput("lit_midreset_err", 64'(err_out), 64'h0);
    checkOutput("lit_midreset_taddr", 64'(taddr_out), 64'h0);
    checkOutput("lit_midreset_errc", 64'(frame_err_cnt_out), 64'h0);
    sendCmd(8'h01, 8'h05, '{8'h03, 8'h00, 8'hA5, 8'h5A, 8'h0F}, 8'h00, 3);
    checkOutput("lit_gap_taddr", 64'(taddr_out), 64'h3_00A5_5A0F);

`ifdef UDP_CMD_TIMEOUT_EN
    sendByte(8'hA5, 0);
    sendByte(8'h01, 0);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) applyStimulus(1'b0, 8'h00);
    checkOutput("lit_timeout_busy_before", 64'(busy_out), 64'h1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("lit_timeout_err", 64'(err_out), 64'h1);
    checkOutput("lit_timeout_busy_after", 64'(busy_out), 64'h0);
`else
    sendByte(8'hA5, 0);
    sendByte(8'h02, 0);
    sendByte(8'h00, 0);
    for (int i = 0; i < 1500; i++) applyStimulus(1'b0, 8'h00);
    checkOutput("lit_hold_busy", 64'(busy_out), 64'h1);
    sendByte(8'h02, 0);
    checkOutput("lit_hold_sc", 64'(self_check_out), 64'h1);
`endif

    // CLR_STATS zeroes both counters without counting itself
    sendCmd(8'h04, 8'h00, '{}, 8'h00, 0);
    checkOutput("lit_clr_ok", 64'(frame_ok_cnt_out), 64'h0);
    checkOutput("lit_clr_err", 64'(frame_err_cnt_out), 64'h0);

    // Randomized mix of good, corrupted and malformed frames with gaps
    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 9);
      pay.delete();
      case (kind)
        0, 1, 2: begin
          for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
          sendCmd(8'h01, 8'h05, pay, 8'h00, 2);
        end
        3: sendCmd(8'h02, 8'h00, pay, 8'h00, 2);
        4: begin
          pay.push_back(8'($urandom));
          sendCmd(8'h03, 8'h01, pay, 8'h00, 2);
        end
        5: begin
          if ($urandom_range(0, 3) == 0) sendCmd(8'h04, 8'h00, pay, 8'h00, 2);
          else sendCmd(8'h02, 8'h00, pay, 8'h00, 2);
        end
        6: begin
          opc = 8'($urandom_range(1, 4));
          len = (opc == 8'h01) ? 8'd5 : (opc == 8'h03) ? 8'd1 : 8'd0;
          for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
          sendCmd(opc, len, pay, 8'($urandom_range(1, 255)), 2);
        end
        7: begin
          opc = 8'($urandom_range(5, 255));
          len = 8'($urandom_range(0, 3));
          for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
          sendCmd(opc, len, pay, 8'h00, 2);
        end
        8: begin
          len = 8'($urandom_range(0, MAX_PAYLOAD));
          if (len == 8'd5) len = 8'd4;
          for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
          sendCmd(8'h01, len, pay, 8'h00, 2);
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            sendByte(8'hA5, 2);
            sendByte(8'($urandom_range(1, 4)), 2);
            sendByte(8'($urandom_range(MAX_PAYLOAD + 1, 255)), 2);
          end else begin
            for (int i = 0; i < 3; i++) sendByte(8'($urandom_range(0, 8'hA4)), 2);
          end
        end
      endcase
    end

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
